// File: rtl/ctrl_pkg.sv
// Shared types for the accumulator-core control sequencer: opcode maps,
// FSM states and the registered strobe bundle.
package ctrl_pkg;

    localparam int unsigned ROP_W = 4;
    localparam int unsigned IOP_W = 3;

    typedef enum logic [ROP_W-1:0] {
        ADD  = 4'd0,
        LOAD = 4'd1,
        STR  = 4'd2,
        MVTO = 4'd3,
        MVFR = 4'd4,
        OR   = 4'd5,
        XOR  = 4'd6,
        XORR = 4'd7,
        AND  = 4'd8,
        SLT  = 4'd9,
        SEQ  = 4'd10,
        SUB  = 4'd11,
        BTRU = 4'd12,
        NOT  = 4'd13
    } r_op_t;

    typedef enum logic [IOP_W-1:0] {
        LUT  = 3'd0,
        ADDI = 3'd1,
        SUBI = 3'd2,
        LSLI = 3'd3,
        B    = 3'd4,
        LSRI = 3'd5
    } i_op_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        MEMWAIT = 2'd2,
        DONE    = 2'd3
    } ctrl_state_t;

    typedef struct packed {
        logic write_r0;
        logic gen_reg_write;
        logic write_mem;
        logic mem_read;
        logic lut_signal;
        logic branch;
    } ctrl_bus_t;

    localparam ctrl_bus_t CTRL_NOP = '0;

endpackage

// File: rtl/ctrl_seq_if.sv
// Instruction-side inputs and control-strobe outputs of ctrl_seq.
interface ctrl_seq_if #(
    parameter int unsigned InstrW = 9
);
    logic              Start;
    logic [InstrW-1:0] Instruction;
    logic              InstrValid;
    logic              BranchCond;
    logic              WriteR0;
    logic              GenRegWrite;
    logic              WriteMem;
    logic              MemRead;
    logic              LUTsignal;
    logic              Branch;
    logic              PcEnable;
    logic              Busy;
    logic              Ack;

    modport master (
        output Start, Instruction, InstrValid, BranchCond,
        input  WriteR0, GenRegWrite, WriteMem, MemRead, LUTsignal, Branch,
               PcEnable, Busy, Ack
    );

    modport slave (
        input  Start, Instruction, InstrValid, BranchCond,
        output WriteR0, GenRegWrite, WriteMem, MemRead, LUTsignal, Branch,
               PcEnable, Busy, Ack
    );
endinterface

// File: rtl/ctrl_decode.sv
// Combinational instruction decoder: opcode fields to strobe bundle plus
// halt/load/store flags used by the sequencer.
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter int unsigned InstrW = 9
) (
    input  logic [InstrW-1:0] instruction,
    input  logic              branch_cond,
    output ctrl_bus_t         bus,
    output logic              is_halt,
    output logic              is_load,
    output logic              is_store
);
    r_op_t r_op;
    i_op_t i_op;

    assign r_op = r_op_t'(instruction[InstrW-3 -: ROP_W]);
    assign i_op = i_op_t'(instruction[InstrW-3 -: IOP_W]);

    // All-ones is halt and overrides whatever the opcode fields say.
    always_comb begin
        bus      = CTRL_NOP;
        is_load  = 1'b0;
        is_store = 1'b0;
        is_halt  = &instruction;
        if (!is_halt) begin
            if (instruction[InstrW-1]) begin
                unique case (r_op)
                    ADD, MVTO, OR, XOR, XORR, AND, SLT, SEQ, SUB, NOT:
                        bus.write_r0 = 1'b1;
                    LOAD: begin
                        bus.write_r0 = 1'b1;
                        bus.mem_read = 1'b1;
                        is_load      = 1'b1;
                    end
                    STR: begin
                        bus.write_mem = 1'b1;
                        is_store      = 1'b1;
                    end
                    MVFR:    bus.gen_reg_write = 1'b1;
                    BTRU:    bus.branch        = branch_cond;
                    default: bus               = CTRL_NOP;
                endcase
            end else begin
                unique case (i_op)
                    ADDI, SUBI, LSLI, LSRI: bus.write_r0 = 1'b1;
                    LUT: begin
                        bus.write_r0   = 1'b1;
                        bus.lut_signal = 1'b1;
                    end
                    B:       bus.branch = 1'b1;
                    default: bus        = CTRL_NOP;
                endcase
            end
        end
    end
endmodule

// File: rtl/ctrl_seq.sv
// Run/stall/done sequencer: registers decoded strobes, stretches LOAD/STR
// over MemLat cycles with the PC held, and squashes the slot after a branch.
module ctrl_seq
    import ctrl_pkg::*;
#(
    parameter int unsigned InstrW        = 9,
    parameter int unsigned MemLat        = 2,
    parameter bit          FlushOnBranch = 1'b1
) (
    input  logic       Clk,
    input  logic       Reset_n,
    ctrl_seq_if.slave  io
);
    localparam int unsigned CntW = $clog2(MemLat + 1);

    ctrl_state_t     state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            load_q, load_d;
    logic            squash_q, squash_d;
    ctrl_bus_t       bus_q, bus_d, dec_bus;
    logic            pc_en_q, pc_en_d;
    logic            busy_q, busy_d;
    logic            ack_q, ack_d;
    logic            dec_halt, dec_load, dec_store;

    ctrl_decode #(.InstrW(InstrW)) u_decode (
        .instruction (io.Instruction),
        .branch_cond (io.BranchCond),
        .bus         (dec_bus),
        .is_halt     (dec_halt),
        .is_load     (dec_load),
        .is_store    (dec_store)
    );

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            load_q   <= 1'b0;
            squash_q <= 1'b0;
            bus_q    <= CTRL_NOP;
            pc_en_q  <= 1'b0;
            busy_q   <= 1'b0;
            ack_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            load_q   <= load_d;
            squash_q <= squash_d;
            bus_q    <= bus_d;
            pc_en_q  <= pc_en_d;
            busy_q   <= busy_d;
            ack_q    <= ack_d;
        end
    end

    // Outputs are computed for the cycle following the edge that loads them.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load_d  = load_q;
        bus_d   = CTRL_NOP;
        pc_en_d = 1'b0;
        ack_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (io.Start) begin
                    state_d = RUN;
                    pc_en_d = 1'b1;
                end
            end
            DONE: begin
                ack_d = 1'b1;
                if (io.Start) begin
                    state_d = RUN;
                    ack_d   = 1'b0;
                    pc_en_d = 1'b1;
                end
            end
            RUN: begin
                pc_en_d = 1'b1;
                if (io.InstrValid && !squash_q) begin
                    if (dec_halt) begin
                        state_d = DONE;
                        ack_d   = 1'b1;
                        pc_en_d = 1'b0;
                    end else begin
                        bus_d = dec_bus;
                        // Multi-cycle memory op: first cycle issues, PC held.
                        if ((dec_load || dec_store) && (MemLat > 1)) begin
                            state_d        = MEMWAIT;
                            cnt_d          = CntW'(MemLat - 1);
                            load_d         = dec_load;
                            pc_en_d        = 1'b0;
                            bus_d.write_r0 = 1'b0;
                        end
                    end
                end
            end
            MEMWAIT: begin
                bus_d.mem_read = load_q;
                if (cnt_q == CntW'(1)) begin
                    state_d        = RUN;
                    cnt_d          = '0;
                    bus_d.write_r0 = load_q;
                    pc_en_d        = 1'b1;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        squash_d = FlushOnBranch && bus_d.branch;
        busy_d   = (state_d == RUN) || (state_d == MEMWAIT);
    end

    assign io.WriteR0     = bus_q.write_r0;
    assign io.GenRegWrite = bus_q.gen_reg_write;
    assign io.WriteMem    = bus_q.write_mem;
    assign io.MemRead     = bus_q.mem_read;
    assign io.LUTsignal   = bus_q.lut_signal;
    assign io.Branch      = bus_q.branch;
    assign io.PcEnable    = pc_en_q;
    assign io.Busy        = busy_q;
    assign io.Ack         = ack_q;
endmodule

// File: tb/tb_ctrl_seq.sv
// Bench for ctrl_seq: four parameterisations share one stimulus stream and are
// compared each cycle against a per-instance output-sequence model.
module tb_ctrl_seq;
    localparam logic [8:0] V_WR0 = 9'h100;
    localparam logic [8:0] V_GRW = 9'h080;
    localparam logic [8:0] V_WM  = 9'h040;
    localparam logic [8:0] V_MR  = 9'h020;
    localparam logic [8:0] V_LUT = 9'h010;
    localparam logic [8:0] V_BR  = 9'h008;
    localparam logic [8:0] V_PC  = 9'h004;
    localparam logic [8:0] V_BSY = 9'h002;
    localparam logic [8:0] V_ACK = 9'h001;

    localparam logic [8:0] I_ADD  = 9'b1_0_0000_101;
    localparam logic [8:0] I_LOAD = 9'b1_0_0001_000;
    localparam logic [8:0] I_STR  = 9'b1_0_0010_000;
    localparam logic [8:0] I_MVFR = 9'b1_0_0100_011;
    localparam logic [8:0] I_BTRU = 9'b1_0_1100_000;
    localparam logic [8:0] I_ADDI = 9'b0_1_001_1010;
    localparam logic [8:0] I_LUT  = 9'b0_0_000_0011;
    localparam logic [8:0] I_B    = 9'b0_0_100_0000;
    localparam logic [8:0] I_HALT = 9'h1FF;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [8:0] instr;
    logic       valid;
    logic       bc;

    int lat   [4] = '{2, 3, 1, 4};
    bit flush [4] = '{1'b1, 1'b1, 1'b1, 1'b0};

    int nchecks = 0;
    int npass   = 0;

    logic [8:0] obs  [4];
    logic [8:0] expv [4];
    logic [8:0] pend [4][8];
    int         pn   [4];
    bit         run  [4];
    bit         ackm [4];
    bit         sq   [4];

    ctrl_seq_if #(.InstrW(9)) if0 ();
    ctrl_seq_if #(.InstrW(9)) if1 ();
    ctrl_seq_if #(.InstrW(9)) if2 ();
    ctrl_seq_if #(.InstrW(9)) if3 ();

    assign if0.Start = start; assign if0.Instruction = instr; assign if0.InstrValid = valid; assign if0.BranchCond = bc;
    assign if1.Start = start; assign if1.Instruction = instr; assign if1.InstrValid = valid; assign if1.BranchCond = bc;
    assign if2.Start = start; assign if2.Instruction = instr; assign if2.InstrValid = valid; assign if2.BranchCond = bc;
    assign if3.Start = start; assign if3.Instruction = instr; assign if3.InstrValid = valid; assign if3.BranchCond = bc;

    ctrl_seq #(.InstrW(9), .MemLat(2), .FlushOnBranch(1'b1)) u_dut0 (.Clk(clk), .Reset_n(rst_n), .io(if0));
    ctrl_seq #(.InstrW(9), .MemLat(3), .FlushOnBranch(1'b1)) u_dut1 (.Clk(clk), .Reset_n(rst_n), .io(if1));
    ctrl_seq #(.InstrW(9), .MemLat(1), .FlushOnBranch(1'b1)) u_dut2 (.Clk(clk), .Reset_n(rst_n), .io(if2));
    ctrl_seq #(.InstrW(9), .MemLat(4), .FlushOnBranch(1'b0)) u_dut3 (.Clk(clk), .Reset_n(rst_n), .io(if3));

    assign obs[0] = {if0.WriteR0, if0.GenRegWrite, if0.WriteMem, if0.MemRead, if0.LUTsignal, if0.Branch, if0.PcEnable, if0.Busy, if0.Ack};
    assign obs[1] = {if1.WriteR0, if1.GenRegWrite, if1.WriteMem, if1.MemRead, if1.LUTsignal, if1.Branch, if1.PcEnable, if1.Busy, if1.Ack};
    assign obs[2] = {if2.WriteR0, if2.GenRegWrite, if2.WriteMem, if2.MemRead, if2.LUTsignal, if2.Branch, if2.PcEnable, if2.Busy, if2.Ack};
    assign obs[3] = {if3.WriteR0, if3.GenRegWrite, if3.WriteMem, if3.MemRead, if3.LUTsignal, if3.Branch, if3.PcEnable, if3.Busy, if3.Ack};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-cycle strobes implied by an instruction's mnemonic.
    function automatic logic [8:0] strobes(input logic [8:0] i, input logic b);
        logic [15:0] r_writes = 16'h2FEB;
        logic [7:0]  i_writes = 8'h2E;
        logic [3:0]  rop = i[6:3];
        logic [2:0]  iop = i[6:4];
        logic [8:0]  s   = '0;
        if (i[8]) begin
            if (r_writes[rop]) s = s | V_WR0;
            if (rop == 4'd1)  s = s | V_MR;
            if (rop == 4'd2)  s = s | V_WM;
            if (rop == 4'd4)  s = s | V_GRW;
            if (rop == 4'd12 && b) s = s | V_BR;
        end else begin
            if (i_writes[iop]) s = s | V_WR0;
            if (iop == 3'd0)  s = s | V_WR0 | V_LUT;
            if (iop == 3'd4)  s = s | V_BR;
        end
        return s;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 4; d++) begin
            run[d] = 1'b0; ackm[d] = 1'b0; sq[d] = 1'b0; pn[d] = 0; expv[d] = '0;
        end
    endtask

    // A memory op expands into a scripted list of future output cycles.
    task automatic model_step(input int d);
        logic [8:0] s, v;
        bit ld, st;
        if (pn[d] > 0) begin
            expv[d] = pend[d][0];
            for (int k = 0; k < 7; k++) pend[d][k] = pend[d][k+1];
            pn[d] = pn[d] - 1;
        end else if (!run[d]) begin
            if (start) begin
                run[d] = 1'b1; ackm[d] = 1'b0; expv[d] = V_PC | V_BSY;
            end else begin
                expv[d] = ackm[d] ? V_ACK : 9'h000;
            end
        end else if (!valid || sq[d]) begin
            sq[d] = 1'b0;
            expv[d] = V_PC | V_BSY;
        end else if (instr == I_HALT) begin
            run[d] = 1'b0; ackm[d] = 1'b1; expv[d] = V_ACK;
        end else begin
            s  = strobes(instr, bc);
            ld = instr[8] && (instr[6:3] == 4'd1);
            st = instr[8] && (instr[6:3] == 4'd2);
            if (ld || st) begin
                for (int k = 1; k <= lat[d]; k++) begin
                    v = V_BSY;
                    if (ld) v = v | V_MR;
                    if (ld && k == lat[d]) v = v | V_WR0;
                    if (st && k == 1) v = v | V_WM;
                    if (k == lat[d]) v = v | V_PC;
                    if (k == 1) expv[d] = v;
                    else begin
                        pend[d][pn[d]] = v;
                        pn[d] = pn[d] + 1;
                    end
                end
            end else begin
                expv[d] = s | V_PC | V_BSY;
                sq[d]   = flush[d] && (s[3] == 1'b1);
            end
        end
    endtask

    task automatic check(input string tag, input int d);
        nchecks++;
        assert (obs[d] === expv[d]) npass++;
        else $error("FAIL %s dut%0d: observed %b expected %b (wr0 grw wm mr lut br pc busy ack)",
                    tag, d, obs[d], expv[d]);
    endtask

    task automatic step(input string tag, input bit st_i, input logic [8:0] in_i,
                        input bit v_i, input bit bc_i);
        start = st_i; instr = in_i; valid = v_i; bc = bc_i;
        @(posedge clk);
        for (int d = 0; d < 4; d++) model_step(d);
        #1;
        for (int d = 0; d < 4; d++) check(tag, d);
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        #1;
        model_reset();
        for (int d = 0; d < 4; d++) check(tag, d);
    endtask

    initial begin
        logic [8:0] ri;
        int sel;
        start = 1'b0; instr = '0; valid = 1'b0; bc = 1'b0;
        rst_n = 1'b1;
        for (int d = 0; d < 4; d++) for (int k = 0; k < 8; k++) pend[d][k] = '0;
        #1;
        do_reset("reset");
        #5 rst_n = 1'b1;

        step("idle_ignores_instr", 1'b0, I_ADD, 1'b1, 1'b0);
        step("start", 1'b1, 9'h000, 1'b0, 1'b0);
        step("addi", 1'b0, I_ADDI, 1'b1, 1'b0);
        step("bubble", 1'b0, 9'h000, 1'b0, 1'b0);
        step("lut", 1'b0, I_LUT, 1'b1, 1'b0);
        step("mvfr", 1'b0, I_MVFR, 1'b1, 1'b0);
        step("load", 1'b0, I_LOAD, 1'b1, 1'b0);
        repeat (4) step("load_stall", 1'b1, I_ADD, 1'b1, 1'b1);
        step("str", 1'b0, I_STR, 1'b1, 1'b0);
        repeat (4) step("after_str", 1'b0, I_ADD, 1'b1, 1'b0);
        step("btru_nc", 1'b0, I_BTRU, 1'b1, 1'b0);
        step("add", 1'b0, I_ADD, 1'b1, 1'b0);
        step("btru_c", 1'b0, I_BTRU, 1'b1, 1'b1);
        step("squash_add", 1'b0, I_ADD, 1'b1, 1'b0);
        step("add_after_squash", 1'b0, I_ADD, 1'b1, 1'b0);
        step("b", 1'b0, I_B, 1'b1, 1'b0);
        step("halt_in_squash", 1'b0, I_HALT, 1'b1, 1'b1);
        step("add", 1'b0, I_ADD, 1'b1, 1'b0);
        step("halt_bc1", 1'b0, I_HALT, 1'b1, 1'b1);
        repeat (10) step("done_hold", 1'b0, 9'($urandom), 1'b1, 1'b1);
        step("restart", 1'b1, I_ADDI, 1'b1, 1'b0);
        step("run_after_restart", 1'b0, I_ADDI, 1'b1, 1'b0);

        step("load_lat4", 1'b0, I_LOAD, 1'b1, 1'b0);
        step("load_lat4_wait", 1'b0, I_ADD, 1'b1, 1'b0);
        #2;
        do_reset("reset_mid_memwait");
        #2 rst_n = 1'b1;
        step("post_reset_idle", 1'b0, I_ADD, 1'b1, 1'b0);
        step("post_reset_start", 1'b1, 9'h000, 1'b0, 1'b0);
        step("post_reset_add", 1'b0, I_ADD, 1'b1, 1'b0);

        repeat (400) begin
            sel = int'($urandom_range(0, 15));
            ri  = 9'($urandom);
            if (sel == 0)      ri = I_HALT;
            else if (sel == 1) ri = I_LOAD;
            else if (sel == 2) ri = I_STR;
            else if (sel == 3) ri = I_BTRU;
            step("random", ($urandom_range(0, 7) == 0), ri,
                 ($urandom_range(0, 3) != 0), 1'($urandom));
        end

        $display("%0d/%0d checks passed", npass, nchecks);
        $finish;
    end
endmodule
